// File: rtl/sipo_shift_reg.sv
// sipo_shift_reg: serial-in, parallel-out shift register.
// One serial bit enters Q[0] on every rising CLK edge while RESET is low.
// Existing words move one position toward the MSB, so the first bit of a word ends up in Q[WIDTH-1].
// RESET is synchronous and active-high, and it takes priority over shifting.
// Optional feature macro: SIPO_VALID_EN. When it is defined, a VALID strobe pulses for one cycle
// each time a full group of WIDTH bits has been shifted in since the last reset.
module sipo_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic             RESET,
  input  logic             IN,
  input  logic             CLK,
  output logic [WIDTH-1:0] Q
`ifdef SIPO_VALID_EN
  ,
  output logic             VALID
`endif
);

  // Shift register: clear on reset, otherwise push IN into the LSB and drop the MSB
  always_ff @(posedge CLK) begin
    if (RESET) begin
      Q <= '0;
    end else begin
      Q <= {Q[WIDTH-2:0], IN};
    end
  end

`ifdef SIPO_VALID_EN
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] bit_cnt;

  // Group counter and strobe: VALID rises on the edge that completes a group of WIDTH bits
  always_ff @(posedge CLK) begin
    if (RESET) begin
      bit_cnt <= '0;
      VALID   <= 1'b0;
    end else if (bit_cnt == CNT_LAST) begin
      bit_cnt <= '0;
      VALID   <= 1'b1;
    end else begin
      bit_cnt <= bit_cnt + CNT_ONE;
      VALID   <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_sipo_shift_reg.sv
// tb_sipo_shift_reg: scoreboard bench for sipo_shift_reg.
// The driver computes the expected word from the serial history since the last reset and queues it.
// A monitor pops and compares one entry after every clock edge.
// VALID is compared too when SIPO_VALID_EN is defined.
module tb_sipo_shift_reg;

  localparam int WIDTH = 4;

  logic             CLK;
  logic             RESET;
  logic             IN;
  logic [WIDTH-1:0] Q;
`ifdef SIPO_VALID_EN
  logic             VALID;
`endif

  typedef struct {
    logic [WIDTH-1:0] q;
    logic             v;
    string            tag;
  } exp_t;

  exp_t sb[$];
  bit   hist[$];
  int   since_reset;
  int   checks;
  int   failures;

  sipo_shift_reg #(.WIDTH(WIDTH)) dut (
    .RESET (RESET),
    .IN    (IN),
    .CLK   (CLK),
    .Q     (Q)
`ifdef SIPO_VALID_EN
    ,
    .VALID (VALID)
`endif
  );

  // Free-running clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one edge's worth of stimulus and queue the response the reference model predicts
  task automatic applyStimulus(input logic rst, input logic din, input string tag);
    exp_t e;
    @(negedge CLK);
    RESET = rst;
    IN    = din;
    if (rst) begin
      hist.delete();
      since_reset = 0;
    end else begin
      hist.push_back(din);
      if (hist.size() > WIDTH) void'(hist.pop_front());
      since_reset++;
    end
    e.q = '0;
    for (int k = 0; k < WIDTH; k++) begin
      if (k < hist.size()) e.q[k] = hist[hist.size() - 1 - k];
    end
    e.v   = (!rst && since_reset > 0 && (since_reset % WIDTH) == 0);
    e.tag = tag;
    sb.push_back(e);
  endtask

  // Compare one DUT sample against the next scoreboard entry
  task automatic checkOutput();
    exp_t e;
    e = sb.pop_front();
    checks++;
    if (Q !== e.q) begin
      failures++;
      $display("[TB] FAIL %s Q: got %b, required %b", e.tag, Q, e.q);
    end
`ifdef SIPO_VALID_EN
    checks++;
    if (VALID !== e.v) begin
      failures++;
      $display("[TB] FAIL %s VALID: got %b, required %b", e.tag, VALID, e.v);
    end
`endif
  endtask

  // Monitor: sample just after each rising edge and check whenever a prediction is pending
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (sb.size() > 0) checkOutput();
    end
  end

  // Main sequence: directed cases from the test plan, then randomized traffic
  initial begin
    logic       r;
    logic       b;
    logic [3:0] word;
    int         wait_cycles;
    checks      = 0;
    failures    = 0;
    since_reset = 0;
    RESET       = 1'b0;
    IN          = 1'b0;

    applyStimulus(1'b1, 1'b1, "reset");

    word = 4'b1011;
    for (int i = WIDTH - 1; i >= 0; i--) applyStimulus(1'b0, word[i], "basic_word");
    applyStimulus(1'b0, 1'b0, "overflow");

    applyStimulus(1'b1, 1'b0, "reset_pre_mid");
    applyStimulus(1'b0, 1'b1, "mid_shift");
    applyStimulus(1'b0, 1'b1, "mid_shift");
    applyStimulus(1'b1, 1'b0, "mid_reset");
    applyStimulus(1'b0, 1'b1, "after_mid_reset");

    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, "reset_priority");

    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'($urandom_range(0, 1)), "stream8");

    applyStimulus(1'b1, 1'b0, "group_reset");
    applyStimulus(1'b0, 1'b1, "partial_group");
    applyStimulus(1'b0, 1'b0, "partial_group");
    applyStimulus(1'b1, 1'b0, "group_reset");
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'($urandom_range(0, 1)), "post_reset_group");

    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 19) == 0);
      b = 1'($urandom_range(0, 1));
      applyStimulus(r, b, "random");
    end

    wait_cycles = 0;
    while (sb.size() > 0 && wait_cycles < 10) begin
      @(posedge CLK);
      #2;
      wait_cycles++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: got %0d pending entries, required 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
